mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between the instruction-fetch requester (IFU) and the load/store requester (MEM stage) of the five-stage pipeline. It grants one transaction at a time and drives a valid/ready request plus a response-valid handshake to memory. It returns completion pulses and registered read data to the winning requester, and emits per-requester stall signals used by the pipeline controller. Load/store has fixed priority over fetch.

## Interface
- XLEN, 64, address/data width (matches `width)
- MASK_W, XLEN/8, byte write-mask width
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done or if_flush
- if_addr  in  XLEN  fetch address
- if_flush  in  1  cancel current/pending fetch (branch redirect)
- if_done  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  XLEN  fetch read data (registered)
- if_stall  out  1  fetch requested and not completing this cycle
- ls_req  in  1  load/store request; held with payload until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  XLEN  data address
- ls_wdata  in  XLEN  store data
- ls_wmask  in  MASK_W  store byte enables
- ls_done  out  1  one-cycle pulse: access complete, ls_rdata valid for loads
- ls_rdata  out  XLEN  load read data (registered)
- ls_stall  out  1  ls_req high and ls_done low
- mem_valid  out  1  request valid to memory
- mem_ready  in  1  memory accepts request when mem_valid & mem_ready
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/XLEN/XLEN/MASK_W  request payload; mem_we=0 for fetch
- mem_resp_valid  in  1  response for the single outstanding request (reads and writes)
- mem_rdata  in  XLEN  read data, valid with mem_resp_valid

## Operation
- States: IDLE, REQ, WAIT. Register owner (IF/LS) and drop flag.
- IDLE: ls_req=1 → latch LS payload, owner=LS, go REQ. Else if_req=1 and if_flush=0 → latch if_addr, owner=IF, go REQ. Else stay.
- REQ: mem_valid=1 and payload driven from the latched registers. On mem_ready → WAIT. mem_valid is never withdrawn before acceptance, including on flush.
- WAIT: on mem_resp_valid → register mem_rdata into the owner's rdata and pulse the owner's done next cycle (suppressed if drop=1), go IDLE.
- Only one transaction is outstanding. mem_resp_valid outside WAIT is ignored.
- Flush: if_flush while owner=IF in REQ/WAIT sets drop; the transaction completes on the bus, but if_done is not pulsed and if_rdata is not updated. if_flush in IDLE blocks the fetch grant that cycle. Flush has no effect on an LS transaction.
- Stores: wait for mem_resp_valid, then ls_done; ls_rdata is unchanged.
- if_stall = if_req & ~if_done & ~if_flush; ls_stall = ls_req & ~ls_done (combinational from registered done).
- Fixed priority: under a continuous ls_req stream, fetch waits. This is acceptable because the pipeline stalls fetch during MEM anyway.

## Timing
- Reset: state=IDLE, drop=0, mem_valid=0, if_done=0, ls_done=0, if_rdata=0, ls_rdata=0, mem payload regs=0. Reset mid-transaction abandons it; a later mem_resp_valid is ignored.
- Minimum latency (mem_ready=1, response next cycle):
  - cycle 0: req sampled in IDLE
  - cycle 1: mem_valid
  - cycle 2: mem_resp_valid
  - cycle 3: done pulse, FSM in IDLE
- Back-to-back: a new grant is sampled in the same cycle the previous done pulses, so the next mem_valid appears at done+1.
- Simultaneous ls_req and if_req in IDLE: LS wins, and IF is granted at the first IDLE with ls_req=0.

## Test plan
- Fetch only: if_req, if_addr=0x8000_0000, mem_ready=1, response next cycle with rdata=0x00100073 → mem_valid cycle 1, if_done + if_rdata=0x00100073 cycle 3, if_stall high cycles 0-2.
- Contention: if_req and ls_req (load 0x8000_1000) both rise in cycle 0 → LS served first (ls_done cycle 3), IF mem_valid cycle 4, if_done cycle 6.
- Store with backpressure: ls_we=1, wmask=0x0F, wdata=0xDEADBEEF, mem_ready low 3 cycles → mem_valid and payload stable throughout, ls_done exactly once after response, ls_rdata unchanged.
- Flush in WAIT: fetch accepted, if_flush pulsed before response → no if_done, if_rdata unchanged; next fetch (new address) issues and completes normally.
- Reset mid-WAIT: assert sys_rst during WAIT, then mem_resp_valid arrives → all outputs 0, no done pulse, FSM IDLE.
- Stray response: mem_resp_valid in IDLE → no done pulse, no rdata change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, load/store has fixed priority
module mem_port_arbiter #(
    parameter int XLEN   = 64,
    parameter int MASK_W = XLEN / 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_stall,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic              ls_done,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              ls_stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;
    logic   owner_ls;
    logic   drop;
    logic   kill;
    // a flush in the response cycle itself also cancels the fetch completion
    assign kill     = drop | (if_flush & ~owner_ls);
    assign if_stall = if_req & ~if_done & ~if_flush;
    assign ls_stall = ls_req & ~ls_done;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            owner_ls  <= 1'b0;
            drop      <= 1'b0;
            mem_valid <= 1'b0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ls_req) begin
                        state     <= REQ;
                        owner_ls  <= 1'b1;
                        drop      <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_we    <= ls_we;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        mem_wmask <= ls_wmask;
                    end else if (if_req && !if_flush) begin
                        state     <= REQ;
                        owner_ls  <= 1'b0;
                        drop      <= 1'b0;
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                    end
                end
                REQ: begin
                    drop <= kill;
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    drop <= kill;
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        if (owner_ls) begin
                            ls_done <= 1'b1;
                            if (!mem_we) ls_rdata <= mem_rdata;
                        end else if (!kill) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cycle table plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
    logic        sys_clk = 1'b0;
    logic        sys_rst, if_req, if_flush, ls_req, ls_we, mem_ready, mem_resp_valid;
    logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [7:0]  ls_wmask;
    logic        if_done, if_stall, ls_done, ls_stall, mem_valid, mem_we;
    logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    mem_port_arbiter dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask), .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_stall(ls_stall),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    // in_f = {rst, if_req, if_flush, ls_req, ls_we, mem_ready, mem_resp_valid}
    // ex   = {mem_valid, if_done, ls_done, if_stall, ls_stall, mem_we}
    typedef struct {
        logic [6:0]  in_f;
        logic [63:0] ifa, lsa, rd;
        logic [5:0]  ex;
        logic [63:0] ea, eifd, elsd;
    } vec_t;
    vec_t tv[35];

    localparam logic [63:0] Z     = 64'h0;
    localparam logic [63:0] A_IF0 = 64'h8000_0000, A_IF1 = 64'h8000_0004;
    localparam logic [63:0] A_IF2 = 64'h8000_0100, A_IF3 = 64'h8000_0200;
    localparam logic [63:0] A_LS0 = 64'h8000_1000, A_ST  = 64'h8000_2000, A_LS1 = 64'h8000_3000;
    localparam logic [63:0] D0 = 64'h0010_0073, D1 = 64'h1111, D2 = 64'h2222, D3 = 64'h9999;
    localparam logic [63:0] D4 = 64'h5555, D5 = 64'h7777, D6 = 64'h8888, D7 = 64'hAAAA;
    localparam logic [63:0] ST_WD = 64'hDEAD_BEEF;
    localparam logic [7:0]  ST_WM = 8'h0F;

    logic        m_busy, m_acc, m_ls, m_drop, m_we, m_ifd, m_lsd;
    logic [63:0] m_addr, m_wd, m_ifrd, m_lsrd;
    logic [7:0]  m_wm;
    logic        pend;
    int          cnt, n_ifd, n_lsd;

    task automatic model_step();
        m_ifd = 1'b0;
        m_lsd = 1'b0;
        if (sys_rst) begin
            {m_busy, m_acc, m_ls, m_drop, m_we} = '0;
            {m_addr, m_wd, m_ifrd, m_lsrd, m_wm} = '0;
        end else if (!m_busy) begin
            if (ls_req) begin
                {m_busy, m_acc, m_ls, m_drop} = 4'b1010;
                {m_we, m_addr, m_wd, m_wm} = {ls_we, ls_addr, ls_wdata, ls_wmask};
            end else if (if_req && !if_flush) begin
                {m_busy, m_acc, m_ls, m_drop} = 4'b1000;
                {m_we, m_addr, m_wd, m_wm} = {1'b0, if_addr, 64'h0, 8'h0};
            end
        end else begin
            if (if_flush && !m_ls) m_drop = 1'b1;
            if (!m_acc) m_acc = mem_ready;
            else if (mem_resp_valid) begin
                m_busy = 1'b0;
                if (m_ls) begin
                    m_lsd = 1'b1;
                    n_lsd++;
                    if (!m_we) m_lsrd = mem_rdata;
                end else if (!m_drop) begin
                    m_ifd = 1'b1;
                    n_ifd++;
                    m_ifrd = mem_rdata;
                end
            end
        end
    endtask

    initial begin
        tv[0]  = '{7'b0100010, A_IF0, Z, Z,  6'b000100, Z, Z, Z};
        tv[1]  = '{7'b0100010, A_IF0, Z, Z,  6'b100100, A_IF0, Z, Z};
        tv[2]  = '{7'b0100001, A_IF0, Z, D0, 6'b000100, Z, Z, Z};
        tv[3]  = '{7'b0000000, Z, Z, Z,      6'b010000, Z, D0, Z};
        tv[4]  = '{7'b0101000, A_IF1, A_LS0, Z,  6'b000110, Z, D0, Z};
        tv[5]  = '{7'b0101010, A_IF1, A_LS0, Z,  6'b100110, A_LS0, D0, Z};
        tv[6]  = '{7'b0101001, A_IF1, A_LS0, D1, 6'b000110, Z, D0, Z};
        tv[7]  = '{7'b0100000, A_IF1, Z, Z,  6'b001100, Z, D0, D1};
        tv[8]  = '{7'b0100010, A_IF1, Z, Z,  6'b100100, A_IF1, D0, D1};
        tv[9]  = '{7'b0100001, A_IF1, Z, D2, 6'b000100, Z, D0, D1};
        tv[10] = '{7'b0000000, Z, Z, Z,      6'b010000, Z, D2, D1};
        tv[11] = '{7'b0001100, Z, A_ST, Z,   6'b000010, Z, D2, D1};
        tv[12] = '{7'b0001100, Z, A_ST, Z,   6'b100011, A_ST, D2, D1};
        tv[13] = '{7'b0001100, Z, A_ST, Z,   6'b100011, A_ST, D2, D1};
        tv[14] = '{7'b0001100, Z, A_ST, Z,   6'b100011, A_ST, D2, D1};
        tv[15] = '{7'b0001110, Z, A_ST, Z,   6'b100011, A_ST, D2, D1};
        tv[16] = '{7'b0001100, Z, A_ST, Z,   6'b000010, Z, D2, D1};
        tv[17] = '{7'b0001101, Z, A_ST, D3,  6'b000010, Z, D2, D1};
        tv[18] = '{7'b0000000, Z, Z, Z,      6'b001000, Z, D2, D1};
        tv[19] = '{7'b0000000, Z, Z, Z,      6'b000000, Z, D2, D1};
        tv[20] = '{7'b0000001, Z, Z, D4,     6'b000000, Z, D2, D1};
        tv[21] = '{7'b0000000, Z, Z, Z,      6'b000000, Z, D2, D1};
        tv[22] = '{7'b0100010, A_IF2, Z, Z,  6'b000100, Z, D2, D1};
        tv[23] = '{7'b0100010, A_IF2, Z, Z,  6'b100100, A_IF2, D2, D1};
        tv[24] = '{7'b0110000, A_IF3, Z, Z,  6'b000000, Z, D2, D1};
        tv[25] = '{7'b0100001, A_IF3, Z, D5, 6'b000100, Z, D2, D1};
        tv[26] = '{7'b0100000, A_IF3, Z, Z,  6'b000100, Z, D2, D1};
        tv[27] = '{7'b0100010, A_IF3, Z, Z,  6'b100100, A_IF3, D2, D1};
        tv[28] = '{7'b0100001, A_IF3, Z, D6, 6'b000100, Z, D2, D1};
        tv[29] = '{7'b0000000, Z, Z, Z,      6'b010000, Z, D6, D1};
        tv[30] = '{7'b0001010, Z, A_LS1, Z,  6'b000010, Z, D6, D1};
        tv[31] = '{7'b0001010, Z, A_LS1, Z,  6'b100010, A_LS1, D6, D1};
        tv[32] = '{7'b1001000, Z, A_LS1, Z,  6'b000010, Z, D6, D1};
        tv[33] = '{7'b0000001, Z, Z, D7,     6'b000000, Z, Z, Z};
        tv[34] = '{7'b0000000, Z, Z, Z,      6'b000000, Z, Z, Z};

        {sys_rst, if_req, if_flush, ls_req, ls_we, mem_ready, mem_resp_valid} = 7'b1000000;
        {if_addr, ls_addr, ls_wdata, mem_rdata, ls_wmask} = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_payload", {mem_we, mem_addr, mem_wdata, mem_wmask} == '0, 1);

        for (int i = 0; i < 35; i++) begin
            {sys_rst, if_req, if_flush, ls_req, ls_we, mem_ready, mem_resp_valid} = tv[i].in_f;
            if_addr   = tv[i].ifa;
            ls_addr   = tv[i].lsa;
            mem_rdata = tv[i].rd;
            ls_wdata  = ls_we ? ST_WD : Z;
            ls_wmask  = ls_we ? ST_WM : 8'h0;
            #1;
            chk($sformatf("v%0d_mem_valid", i), mem_valid, tv[i].ex[5]);
            chk($sformatf("v%0d_if_done", i),   if_done,   tv[i].ex[4]);
            chk($sformatf("v%0d_ls_done", i),   ls_done,   tv[i].ex[3]);
            chk($sformatf("v%0d_if_stall", i),  if_stall,  tv[i].ex[2]);
            chk($sformatf("v%0d_ls_stall", i),  ls_stall,  tv[i].ex[1]);
            chk($sformatf("v%0d_if_rdata", i),  if_rdata,  tv[i].eifd);
            chk($sformatf("v%0d_ls_rdata", i),  ls_rdata,  tv[i].elsd);
            if (tv[i].ex[5]) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr, tv[i].ea);
                chk($sformatf("v%0d_mem_we", i),   mem_we,   tv[i].ex[0]);
                if (tv[i].ex[0]) begin
                    chk($sformatf("v%0d_mem_wdata", i), mem_wdata, ST_WD);
                    chk($sformatf("v%0d_mem_wmask", i), mem_wmask, ST_WM);
                end
            end
            @(posedge sys_clk);
            #1;
        end

        {m_busy, m_acc, m_ls, m_drop, m_we, m_ifd, m_lsd} = '0;
        {m_addr, m_wd, m_ifrd, m_lsrd, m_wm} = '0;
        pend = 1'b0; cnt = 0; n_ifd = 0; n_lsd = 0;
        {if_req, ls_req} = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            chk("r_mem_valid", mem_valid, m_busy && !m_acc);
            if (m_busy && !m_acc)
                chk("r_payload", {mem_we, mem_addr, mem_wdata, mem_wmask}, {m_we, m_addr, m_wd, m_wm} == {mem_we, mem_addr, mem_wdata, mem_wmask} ? {mem_we, mem_addr, mem_wdata, mem_wmask} : {m_we, m_addr, m_wd, m_wm});
            chk("r_if_done", if_done, m_ifd);
            chk("r_ls_done", ls_done, m_lsd);
            chk("r_if_rdata", if_rdata, m_ifrd);
            chk("r_ls_rdata", ls_rdata, m_lsrd);
            sys_rst = ($urandom % 300 == 0);
            if (ls_req && ls_done) ls_req = 1'b0;
            else if (!ls_req && $urandom % 3 == 0) begin
                ls_req   = 1'b1;
                ls_we    = 1'($urandom % 2);
                ls_addr  = {$urandom, $urandom};
                ls_wdata = {$urandom, $urandom};
                ls_wmask = 8'($urandom);
            end
            if_flush = ($urandom % 8 == 0);
            if (if_req && if_done) if_req = 1'b0;
            else if (if_flush) if_addr = {$urandom, $urandom};
            else if (!if_req && $urandom % 2 == 0) begin
                if_req  = 1'b1;
                if_addr = {$urandom, $urandom};
            end
            if (pend) begin
                mem_resp_valid = (cnt == 0);
                if (cnt == 0) pend = 1'b0;
                else cnt--;
            end else mem_resp_valid = ($urandom % 12 == 0);
            mem_rdata = {$urandom, $urandom};
            mem_ready = 1'($urandom % 2);
            #1;
            chk("r_if_stall", if_stall, if_req && !m_ifd && !if_flush);
            chk("r_ls_stall", ls_stall, ls_req && !m_lsd);
            if (mem_valid && mem_ready) begin
                pend = 1'b1;
                cnt  = int'($urandom % 3);
            end
            model_step();
            @(posedge sys_clk);
            #1;
        end
        chk("r_if_done_seen", n_ifd > 0, 1);
        chk("r_ls_done_seen", n_lsd > 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
